bid_agent: RTL and testbench



---
 rtl/bid_agent.sv | 181 ++++++++++++++++++
 tb/tb_bid_agent.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bid_agent.sv
`default_nettype none
// =============================================================================
// bid_agent : per-bidder request FIFO and issue FSM (bid/retract pulse, ack/err/timeout response,
//             round-end capture). Optional build macro: BID_AGENT_RETRY_EN. Revision 1.0
// =============================================================================
module bid_agent #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [15:0] req_amt,
   input  logic        req_retract,
   output logic        bid,
   output logic [15:0] bidAmt,
   output logic        retract,
   input  logic        ack,
   input  logic [1:0]  err,
   input  logic [31:0] balance,
   input  logic        win,
   input  logic        roundOver,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [2:0]  rsp_code,
   output logic        round_win,
   output logic [31:0] round_balance
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t         state, state_nxt;
   logic [16:0]    mem [DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [CW-1:0]  count;
   logic           fl_retract;
   logic [15:0]    fl_amt;
   logic [TW-1:0]  timer;
   logic [2:0]     code;
   logic           round_over_q;
   logic           round_edge, flush, push, pop;
`ifdef BID_AGENT_RETRY_EN
   logic           retried;
`endif

   assign req_ready  = (count < CNT_FULL);
   assign push       = req_valid && req_ready;
   assign round_edge = roundOver && !round_over_q;
   // A round end seen while idle discards everything still queued, including a same-cycle push.
   assign flush      = round_edge && (state == IDLE);
   assign pop        = (state == IDLE) && (count != '0) && !flush;
   assign rsp_code   = code;

   always_ff @(posedge clk) begin
      if (push && !flush)
         mem[wr_ptr] <= {req_retract, req_amt};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= wr_ptr;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)
            count <= count + CW'(1);
         else if (pop && !push)
            count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      bid       = 1'b0;
      retract   = 1'b0;
      bidAmt    = '0;
      rsp_valid = 1'b0;
      case (state)
         IDLE:  if (pop) state_nxt = ISSUE;
         ISSUE: begin
            bid       = !fl_retract;
            retract   = fl_retract;
            bidAmt    = fl_retract ? 16'h0000 : fl_amt;
            state_nxt = WAIT;
         end
         WAIT: begin
            if ((err != 2'b00) || ack)
               state_nxt = RESP;
            else if (timer == T_LAST) begin
`ifdef BID_AGENT_RETRY_EN
               state_nxt = retried ? RESP : ISSUE;
`else
               state_nxt = RESP;
`endif
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fl_retract <= 1'b0;
         fl_amt     <= '0;
         timer      <= '0;
         code       <= '0;
`ifdef BID_AGENT_RETRY_EN
         retried    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE:  if (pop) {fl_retract, fl_amt} <= mem[rd_ptr];
            ISSUE: timer <= '0;
            WAIT: begin
               // err outranks a simultaneous ack
               if (err != 2'b00)
                  code <= {1'b0, err};
               else if (ack)
                  code <= 3'b000;
               else if (timer == T_LAST) begin
`ifdef BID_AGENT_RETRY_EN
                  if (!retried)
                     retried <= 1'b1;
                  else
                     code <= 3'b100;
`else
                  code <= 3'b100;
`endif
               end else
                  timer <= timer + TW'(1);
            end
            RESP: begin
`ifdef BID_AGENT_RETRY_EN
               if (rsp_ready) retried <= 1'b0;
`endif
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         round_over_q  <= 1'b0;
         round_win     <= 1'b0;
         round_balance <= '0;
      end else begin
         round_over_q <= roundOver;
         if (round_edge) begin
            round_win     <= win;
            round_balance <= balance;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bid_agent.sv
`default_nettype none
// =============================================================================
// tb_bid_agent : directed self-checking bench for bid_agent (DEPTH=4, TIMEOUT=16).
// Revision 1.0
// =============================================================================
module tb_bid_agent;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [15:0] req_amt = '0;
   logic        req_retract = 1'b0;
   logic        bid;
   logic [15:0] bidAmt;
   logic        retract;
   logic        ack = 1'b0;
   logic [1:0]  err = 2'b00;
   logic [31:0] balance = '0;
   logic        win = 1'b0;
   logic        roundOver = 1'b0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [2:0]  rsp_code;
   logic        round_win;
   logic [31:0] round_balance;

   int tests_run = 0;
   int tests_failed = 0;
   logic [15:0] seen_amt [0:7];
   int          seen_cyc [0:7];
   int          nb, nrsp, first_rsp;
   logic [2:0]  first_code;

   bid_agent #(.DEPTH(4), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_amt(req_amt), .req_retract(req_retract), .bid(bid), .bidAmt(bidAmt),
      .retract(retract), .ack(ack), .err(err), .balance(balance), .win(win),
      .roundOver(roundOver), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_code(rsp_code), .round_win(round_win), .round_balance(round_balance)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1);
   end

   // Called at a negedge; the push happens on the following posedge, returns at the next negedge.
   task automatic push_one(input logic r, input logic [15:0] a);
      req_valid = 1'b1; req_retract = r; req_amt = a;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Observe n cycles: log bid pulses, response handshakes and the first response.
   task automatic observe(input int n);
      nb = 0; nrsp = 0; first_rsp = -1; first_code = '0;
      for (int c = 1; c <= n; c++) begin
         @(negedge clk);
         if (bid || retract) begin
            if (nb < 8) begin seen_amt[nb] = bidAmt; seen_cyc[nb] = c; end
            nb++;
         end
         if (rsp_valid && first_rsp < 0) begin first_rsp = c; first_code = rsp_code; end
         if (rsp_valid && rsp_ready) nrsp++;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
      tests_run++; if ({bid, retract, rsp_valid, round_win} !== 4'b0000) begin tests_failed++; $display("FAIL reset_pulses: got %b expected 0000", {bid, retract, rsp_valid, round_win}); end
      tests_run++; if ({bidAmt, rsp_code, round_balance} !== 51'd0) begin tests_failed++; $display("FAIL reset_buses: got %h expected 0", {bidAmt, rsp_code, round_balance}); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic_bid;
      rsp_ready = 1'b1;
      push_one(1'b0, 16'h0040);
      tests_run++; if (bid !== 1'b0) begin tests_failed++; $display("FAIL basic_no_early_bid: got %b expected 0", bid); end
      @(negedge clk);
      tests_run++; if ({bid, retract} !== 2'b10) begin tests_failed++; $display("FAIL basic_bid_pulse: got %b expected 10", {bid, retract}); end
      tests_run++; if (bidAmt !== 16'h0040) begin tests_failed++; $display("FAIL basic_bid_amt: got %h expected 0040", bidAmt); end
      ack = 1'b1;                        // ack during ISSUE must be ignored
      @(negedge clk);
      ack = 1'b0;
      tests_run++; if ({bid, rsp_valid} !== 2'b00) begin tests_failed++; $display("FAIL basic_single_pulse: got %b expected 00", {bid, rsp_valid}); end
      @(negedge clk);
      tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_issue_ack_ignored: got %b expected 0", rsp_valid); end
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      tests_run++; if ({rsp_valid, rsp_code} !== 4'b1_000) begin tests_failed++; $display("FAIL basic_rsp: got %b expected 1000", {rsp_valid, rsp_code}); end
      @(negedge clk);
      tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_rsp_done: got %b expected 0", rsp_valid); end
   endtask

   task automatic test_error_priority;
      push_one(1'b0, 16'h1234);
      @(negedge clk);
      @(negedge clk);
      ack = 1'b1; err = 2'b10;
      @(negedge clk);
      ack = 1'b0; err = 2'b00;
      tests_run++; if ({rsp_valid, rsp_code} !== 4'b1_010) begin tests_failed++; $display("FAIL err_priority_funds: got %b expected 1010", {rsp_valid, rsp_code}); end
      @(negedge clk);
      push_one(1'b1, 16'hBEEF);
      @(negedge clk);
      tests_run++; if ({bid, retract} !== 2'b01) begin tests_failed++; $display("FAIL retract_pulse: got %b expected 01", {bid, retract}); end
      tests_run++; if (bidAmt !== 16'h0000) begin tests_failed++; $display("FAIL retract_amt_zero: got %h expected 0000", bidAmt); end
      @(negedge clk);
      err = 2'b01;
      @(negedge clk);
      err = 2'b00;
      tests_run++; if ({rsp_valid, rsp_code} !== 4'b1_001) begin tests_failed++; $display("FAIL err_round_inactive: got %b expected 1001", {rsp_valid, rsp_code}); end
      @(negedge clk);
   endtask

   task automatic test_back_pressure;
      rsp_ready = 1'b0; ack = 1'b1;
      push_one(1'b0, 16'h0011);
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         tests_run++; if ({rsp_valid, rsp_code} !== 4'b1_000) begin tests_failed++; $display("FAIL bp_rsp_held_%0d: got %b expected 1000", k, {rsp_valid, rsp_code}); end
         @(negedge clk);
      end
      for (int i = 0; i < 4; i++) begin
         tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_before_push_%0d: got %b expected 1", i, req_ready); end
         req_valid = 1'b1; req_retract = 1'b0; req_amt = 16'h0022 + 16'(i * 17);
         @(negedge clk);
      end
      req_amt = 16'h0066;
      tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_full: got %b expected 0", req_ready); end
      @(negedge clk);
      tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_full_hold: got %b expected 0", req_ready); end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      observe(30);
      tests_run++; if (nb !== 4) begin tests_failed++; $display("FAIL bp_drain_count: got %0d expected 4", nb); end
      for (int i = 0; i < 4; i++) begin
         tests_run++; if (seen_amt[i] !== 16'h0022 + 16'(i * 17)) begin tests_failed++; $display("FAIL bp_order_%0d: got %h expected %h", i, seen_amt[i], 16'h0022 + 16'(i * 17)); end
         tests_run++; if (seen_cyc[i] !== 2 + 4 * i) begin tests_failed++; $display("FAIL bp_spacing_%0d: got cycle %0d expected %0d", i, seen_cyc[i], 2 + 4 * i); end
      end
      tests_run++; if (nrsp !== 4) begin tests_failed++; $display("FAIL bp_rsp_count: got %0d expected 4", nrsp); end
      ack = 1'b0;
   endtask

   task automatic test_timeout;
      ack = 1'b0; err = 2'b00; rsp_ready = 1'b1;
      push_one(1'b0, 16'h0077);
      observe(60);
      tests_run++; if (first_code !== 3'b100) begin tests_failed++; $display("FAIL timeout_code: got %b expected 100", first_code); end
      tests_run++; if (seen_cyc[0] !== 1 || seen_amt[0] !== 16'h0077) begin tests_failed++; $display("FAIL timeout_first_bid: got cycle %0d amt %h expected 1 0077", seen_cyc[0], seen_amt[0]); end
`ifdef BID_AGENT_RETRY_EN
      tests_run++; if (nb !== 2) begin tests_failed++; $display("FAIL retry_bid_count: got %0d expected 2", nb); end
      tests_run++; if (seen_cyc[1] !== 18 || seen_amt[1] !== 16'h0077) begin tests_failed++; $display("FAIL retry_second_bid: got cycle %0d amt %h expected 18 0077", seen_cyc[1], seen_amt[1]); end
      tests_run++; if (first_rsp !== 35) begin tests_failed++; $display("FAIL retry_rsp_cycle: got %0d expected 35", first_rsp); end
`else
      tests_run++; if (nb !== 1) begin tests_failed++; $display("FAIL timeout_bid_count: got %0d expected 1", nb); end
      tests_run++; if (first_rsp !== 18) begin tests_failed++; $display("FAIL timeout_rsp_cycle: got %0d expected 18", first_rsp); end
`endif
   endtask

   task automatic test_round_end;
      ack = 1'b0; rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL round_ready_%0d: got %b expected 1", i, req_ready); end
         req_valid = 1'b1; req_retract = 1'b0; req_amt = 16'h00A1 + 16'(i);
         @(negedge clk);
      end
      req_valid = 1'b0;
      roundOver = 1'b1; win = 1'b1; balance = 32'h0000_0120;
      @(negedge clk);
      win = 1'b0; balance = 32'h0000_DEAD;
      tests_run++; if ({round_win, round_balance} !== {1'b1, 32'h0000_0120}) begin tests_failed++; $display("FAIL round_capture: got %b %h expected 1 00000120", round_win, round_balance); end
      @(negedge clk);
      roundOver = 1'b0;
      tests_run++; if ({round_win, round_balance} !== {1'b1, 32'h0000_0120}) begin tests_failed++; $display("FAIL round_hold: got %b %h expected 1 00000120", round_win, round_balance); end
      tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL round_inflight_waiting: got %b expected 0", rsp_valid); end
      ack = 1'b1;
      observe(30);
      ack = 1'b0;
      tests_run++; if (nrsp !== 4) begin tests_failed++; $display("FAIL round_rsp_count: got %0d expected 4", nrsp); end
      tests_run++; if (nb !== 3) begin tests_failed++; $display("FAIL round_queued_kept: got %0d expected 3", nb); end
      for (int i = 0; i < 3; i++) begin
         tests_run++; if (seen_amt[i] !== 16'h00A2 + 16'(i)) begin tests_failed++; $display("FAIL round_order_%0d: got %h expected %h", i, seen_amt[i], 16'h00A2 + 16'(i)); end
      end
   endtask

   task automatic test_round_flush;
      ack = 1'b1;
      req_valid = 1'b1; req_retract = 1'b0; req_amt = 16'h00B1;
      @(negedge clk);
      req_valid = 1'b0;
      roundOver = 1'b1; win = 1'b0; balance = 32'h55AA_55AA;
      @(negedge clk);
      roundOver = 1'b0;
      tests_run++; if ({round_win, round_balance} !== {1'b0, 32'h55AA_55AA}) begin tests_failed++; $display("FAIL flush_capture: got %b %h expected 0 55aa55aa", round_win, round_balance); end
      observe(10);
      tests_run++; if (nb !== 0) begin tests_failed++; $display("FAIL flush_no_issue: got %0d pulses expected 0", nb); end
      ack = 1'b0;
   endtask

   task automatic test_midop_reset;
      ack = 1'b0; rsp_ready = 1'b1;
      push_one(1'b0, 16'h0099);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      tests_run++; if ({bid, retract, rsp_valid, req_ready} !== 4'b0001) begin tests_failed++; $display("FAIL midreset_ctrl: got %b expected 0001", {bid, retract, rsp_valid, req_ready}); end
      tests_run++; if ({round_win, round_balance, rsp_code, bidAmt} !== 52'd0) begin tests_failed++; $display("FAIL midreset_buses: got %h expected 0", {round_win, round_balance, rsp_code, bidAmt}); end
      ack = 1'b1;
      observe(12);
      ack = 1'b0;
      tests_run++; if (nb !== 0 || first_rsp !== -1) begin tests_failed++; $display("FAIL midreset_discard: got %0d pulses rsp at %0d expected 0 and -1", nb, first_rsp); end
   endtask

   initial begin
      @(negedge clk);
      test_reset;
      test_basic_bid;
      test_error_priority;
      test_back_pressure;
      test_timeout;
      test_round_end;
      test_round_flush;
      test_midop_reset;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
`default_nettype wire
